// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetcher.
// Cache geometry defaults, bus widths and a byte-assembly helper.
package inst_fetch_pkg;

  localparam int XLEN           = 32;
  localparam int ICACHE_ENTRIES = 64;
  localparam int IDX_W          = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  function automatic logic [XLEN-1:0] le_word(
    input logic [7:0] b3,
    input logic [7:0] b2,
    input logic [7:0] b1,
    input logic [7:0] b0
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Ports: clk/rst, i_rd_pc lookup -> o_hit/o_data (combinational),
//        i_we/i_wr_idx/i_wr_tag/i_wr_data synchronous write.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int ENTRIES = ICACHE_ENTRIES,
  parameter int IW      = IDX_W,
  localparam int TAG_W  = XLEN - IW - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  i_rd_pc,
  output logic             o_hit,
  output logic [XLEN-1:0]  o_data,
  input  logic             i_we,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_data
);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [XLEN-1:0]    r_data [ENTRIES];

  logic [IW-1:0]    w_idx;
  logic [TAG_W-1:0] w_tag;

  assign w_idx  = i_rd_pc[IW+1:2];
  assign w_tag  = i_rd_pc[XLEN-1:IW+2];
  // Only word-aligned addresses can ever hit.
  assign o_hit  = r_valid[w_idx]
                & (r_tag[w_idx] == w_tag)
                & (i_rd_pc[1:0] == 2'b00);
  assign o_data = r_data[w_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetcher: icache lookup, byte-wise RAM refill on miss.
// Ports: clk/rst/rdy, fetch_req/pc_i/flush from IF, mem_* to arbiter,
//        inst_done/inst_o/pc_o back to IF.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_ENTRIES = inst_fetch_pkg::ICACHE_ENTRIES,
  parameter int IDX_W          = inst_fetch_pkg::IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush,
  input  logic            mem_gnt,
  input  logic [7:0]      mem_din,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_a,
  output logic            mem_wr,
  output logic            inst_done,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [XLEN-1:0] r_req_pc;
  logic [2:0]      r_issue_cnt;
  logic [2:0]      r_recv_cnt;
  logic            r_rd_pend;
  logic [7:0]      r_buf [3];
  logic            r_done;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;

  logic            w_hit;
  logic [XLEN-1:0] w_line;
  logic            w_hit_take;
  logic            w_start;
  logic            w_issue;
  logic            w_cap;
  logic            w_last;
  logic            w_cwe;
  logic [XLEN-1:0] w_word;

  inst_fetch_icache #(
    .ENTRIES (ICACHE_ENTRIES),
    .IW      (IDX_W)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .i_rd_pc   (pc_i),
    .o_hit     (w_hit),
    .o_data    (w_line),
    .i_we      (w_cwe),
    .i_wr_idx  (r_req_pc[IDX_W+1:2]),
    .i_wr_tag  (r_req_pc[XLEN-1:IDX_W+2]),
    .i_wr_data (w_word)
  );

  // A byte in flight is taken regardless of rdy; flush discards it.
  assign w_cap  = (r_state == S_BUSY) & r_rd_pend & ~flush;
  assign w_last = w_cap & (r_recv_cnt == 3'd3);
  assign w_cwe  = w_last & (r_req_pc[1:0] == 2'b00);
  assign w_word = le_word(mem_din, r_buf[2], r_buf[1], r_buf[0]);

  assign mem_wr    = FALSE;
  assign inst_done = r_done;
  assign inst_o    = r_inst;
  assign pc_o      = r_pc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_hit_take = 1'b0;
    w_start    = 1'b0;
    w_issue    = 1'b0;
    mem_req    = 1'b0;
    mem_a      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (rdy && fetch_req && !flush) begin
          if (w_hit) begin
            w_hit_take = 1'b1;
          end else begin
            w_start    = 1'b1;
            w_state_nx = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        mem_req = (r_issue_cnt < 3'd4) & ~flush;
        if (mem_req && mem_gnt && rdy) begin
          w_issue = 1'b1;
          mem_a   = r_req_pc + {29'd0, r_issue_cnt};
        end
        if (w_last) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc    <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_buf[2]    <= '0;
      r_done      <= 1'b0;
      r_inst      <= '0;
      r_pc        <= '0;
    end else begin
      r_done    <= 1'b0;
      r_rd_pend <= w_issue;
      if (w_hit_take) begin
        r_done <= 1'b1;
        r_inst <= w_line;
        r_pc   <= pc_i;
      end
      if (w_start) begin
        r_req_pc    <= pc_i;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end
      if (w_issue) r_issue_cnt <= r_issue_cnt + 3'd1;
      if (w_cap) begin
        r_recv_cnt <= r_recv_cnt + 3'd1;
        if (w_last) begin
          r_done <= 1'b1;
          r_inst <= w_word;
          r_pc   <= r_req_pc;
        end else begin
          r_buf[r_recv_cnt[1:0]] <= mem_din;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch.
// Byte RAM model plus hand-computed expected words and latencies.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] pc_i;
  logic        flush;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        inst_done;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int vec = 0;
  int bad = 0;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .fetch_req (fetch_req),
    .pc_i      (pc_i),
    .flush     (flush),
    .mem_gnt   (mem_gnt),
    .mem_din   (mem_din),
    .mem_req   (mem_req),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .inst_done (inst_done),
    .inst_o    (inst_o),
    .pc_o      (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram(input logic [31:0] a);
    if (a == 32'd0)      return 8'h13;
    else if (a == 32'd1) return 8'h05;
    else if (a < 32'd4)  return 8'h00;
    else                 return a[7:0] + 8'h11;
  endfunction

  always @(posedge clk) mem_din <= ram(mem_a);

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    vec++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] gmask,
                       input logic [31:0] rmask, output int dc,
                       output logic [127:0] alog);
    int n;
    n = 0;
    dc = -1;
    alog = '0;
    next();
    chk("idle_done_low", {127'd0, inst_done}, 128'd0);
    fetch_req = 1'b1;
    pc_i = pc;
    mem_gnt = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    next();
    fetch_req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      mem_gnt = !gmask[k];
      rdy = !rmask[k];
      #1;
      if (mem_req && mem_gnt && rdy && n < 4) begin
        alog[n*32 +: 32] = mem_a;
        n++;
      end
      if (inst_done) begin
        dc = k;
        break;
      end
      next();
    end
    mem_gnt = 1'b1;
    rdy = 1'b1;
  endtask

  initial begin
    int dc;
    int seen;
    logic [127:0] al;
    rst = 1'b1;
    rdy = 1'b1;
    fetch_req = 1'b0;
    flush = 1'b0;
    mem_gnt = 1'b1;
    pc_i = '0;
    next();
    next();
    chk("rst_done", {127'd0, inst_done}, 128'd0);
    chk("rst_inst", {96'd0, inst_o}, 128'd0);
    chk("rst_pc", {96'd0, pc_o}, 128'd0);
    chk("rst_req", {127'd0, mem_req}, 128'd0);
    chk("rst_a", {96'd0, mem_a}, 128'd0);
    chk("rst_wr", {127'd0, mem_wr}, 128'd0);
    rst = 1'b0;

    fetch(32'h0, 0, 0, dc, al);
    chk("cold_lat", dc, 6);
    chk("cold_inst", {96'd0, inst_o}, 128'h513);
    chk("cold_pc", {96'd0, pc_o}, 128'd0);
    chk("cold_addr", al, {32'd3, 32'd2, 32'd1, 32'd0});

    fetch(32'h0, 0, 0, dc, al);
    chk("hit_lat", dc, 1);
    chk("hit_inst", {96'd0, inst_o}, 128'h513);
    chk("hit_noreq", al, 128'd0);

    fetch(32'h100, 32'h0000_000C, 0, dc, al);
    chk("gnt_lat", dc, 8);
    chk("gnt_inst", {96'd0, inst_o}, 128'h14131211);
    chk("gnt_pc", {96'd0, pc_o}, 128'h100);

    fetch(32'h0, 0, 0, dc, al);
    chk("alias0_lat", dc, 6);
    chk("alias0_inst", {96'd0, inst_o}, 128'h513);
    fetch(32'h100, 0, 0, dc, al);
    chk("alias1_lat", dc, 6);

    next();
    fetch_req = 1'b1;
    pc_i = 32'h204;
    next();
    fetch_req = 1'b0;
    next();
    next();
    flush = 1'b1;
    next();
    flush = 1'b0;
    #1;
    chk("flush_noreq", {127'd0, mem_req}, 128'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_done) seen++;
      next();
    end
    chk("flush_no_done", seen, 0);
    fetch(32'h204, 0, 0, dc, al);
    chk("postflush_lat", dc, 6);
    chk("postflush_inst", {96'd0, inst_o}, 128'h18171615);
    chk("postflush_pc", {96'd0, pc_o}, 128'h204);
    fetch(32'h204, 0, 0, dc, al);
    chk("postflush_hit", dc, 1);

    next();
    fetch_req = 1'b1;
    pc_i = 32'h204;
    flush = 1'b1;
    next();
    fetch_req = 1'b0;
    flush = 1'b0;
    chk("flush_hit_t1", {127'd0, inst_done}, 128'd0);
    next();
    chk("flush_hit_t2", {127'd0, inst_done}, 128'd0);
    fetch(32'h204, 0, 0, dc, al);
    chk("survive_flush", dc, 1);

    fetch(32'h2, 0, 0, dc, al);
    chk("mis_lat", dc, 6);
    chk("mis_inst", {96'd0, inst_o}, 128'h16150000);
    chk("mis_pc", {96'd0, pc_o}, 128'h2);
    fetch(32'h2, 0, 0, dc, al);
    chk("mis_nocache", dc, 6);

    fetch(32'hFFFF_FFFE, 0, 0, dc, al);
    chk("wrap_lat", dc, 6);
    chk("wrap_inst", {96'd0, inst_o}, 128'h0513100F);
    chk("wrap_addr", al,
        {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});

    fetch(32'h308, 0, 32'h0000_001C, dc, al);
    chk("rdy_lat", dc, 9);
    chk("rdy_inst", {96'd0, inst_o}, 128'h1C1B1A19);

    next();
    fetch_req = 1'b1;
    pc_i = 32'h40C;
    next();
    fetch_req = 1'b0;
    next();
    next();
    rst = 1'b1;
    next();
    chk("mrst_done", {127'd0, inst_done}, 128'd0);
    chk("mrst_inst", {96'd0, inst_o}, 128'd0);
    chk("mrst_pc", {96'd0, pc_o}, 128'd0);
    chk("mrst_req", {127'd0, mem_req}, 128'd0);
    chk("mrst_a", {96'd0, mem_a}, 128'd0);
    rst = 1'b0;
    fetch(32'h204, 0, 0, dc, al);
    chk("cold_after_rst", dc, 6);
    chk("cold_after_rst_inst", {96'd0, inst_o}, 128'h18171615);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
